// File: rtl/mopshub_io_pkg.sv
// Shared constants for the MOPSHUB board input conditioning: debounce and
// long-press timings for the supported clock rates, and front-panel channel map.
package mopshub_io_pkg;

  localparam int N_CH_DEFAULT         = 9;

  localparam int DEB_CYCLES_40MHZ     = 400_000;      // 10 ms
  localparam int DEB_CYCLES_100MHZ    = 1_000_000;    // 10 ms
  localparam int LONG_CYCLES_40MHZ    = 80_000_000;   // 2 s
  localparam int LONG_CYCLES_100MHZ   = 200_000_000;  // 2 s

  localparam int CH_RST_REQ   = 0;
  localparam int CH_DBG_TRIG  = 1;
  localparam int CH_MODE_SEL0 = 2;
  localparam int CH_MODE_SEL1 = 3;
  localparam int CH_MODE_SEL2 = 4;
  localparam int CH_DIP0      = 5;
  localparam int CH_DIP1      = 6;
  localparam int CH_DIP2      = 7;
  localparam int CH_DIP3      = 8;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchronizer, debounce counter, accepted level and
// edge pulses. Long-press detection is built only with BUTTON_DEBOUNCE_LONG_PRESS_EN.
module debounce_channel
  import mopshub_io_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_100MHZ,
  parameter int LONG_CYCLES = LONG_CYCLES_100MHZ,
  parameter bit INVERT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end

  logic          sync1_reg;
  logic          sync2_reg;
  logic          state_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;
  logic          release_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      state_reg   <= 1'b0;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg   <= pin ^ INVERT;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (sync2_reg == state_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // input has disagreed for DEB_CYCLES edges in a row: accept it
        state_reg   <= sync2_reg;
        cnt_reg     <= '0;
        press_reg   <= sync2_reg;
        release_reg <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level         = state_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_FIRE = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0] hold_reg;
  logic          long_reg;

  // saturating one past the fire value guarantees a single pulse per press
  always_ff @(posedge clk) begin
    if (rst || !state_reg) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      long_reg <= (hold_reg == HOLD_FIRE);
      if (hold_reg != HOLD_SAT) begin
        hold_reg <= hold_reg + LW'(1);
      end
    end
  end

  assign long_pulse = long_reg;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_pulse.sv
// Multi-channel push-button / DIP-switch conditioner: debounced levels plus
// press/release pulses. Optional long-press pulses via BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce_pulse
  import mopshub_io_pkg::*;
#(
  parameter int              N_CH        = N_CH_DEFAULT,
  parameter int              DEB_CYCLES  = DEB_CYCLES_100MHZ,
  parameter int              LONG_CYCLES = LONG_CYCLES_100MHZ,
  parameter logic [N_CH-1:0] IN_INVERT   = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .INVERT      (IN_INVERT[gi])
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .pin           (btn_in[gi]),
      .level         (level_out[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .long_pulse    (long_pulse[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: vector table, hand-written corner sequences
// and randomized traffic checked every cycle against a behavioural model.
module tb_button_debounce_pulse;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam logic [N-1:0] INV_B = 2'b10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;

  logic [N-1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [N-1:0] lvl_b, prs_b, rel_b, lng_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce_pulse #(.N_CH(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .IN_INVERT(2'b00)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn),
    .level_out(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a), .long_pulse(lng_a)
  );

  button_debounce_pulse #(.N_CH(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .IN_INVERT(INV_B)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn),
    .level_out(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b), .long_pulse(lng_b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the pin reaches the decision point two edges late; an
  // accepted change needs DEB consecutive edges of disagreement with the level.
  bit [N-1:0] m_p1[2], m_p2[2], m_lvl[2], m_prs[2], m_rel[2], m_lng[2];
  int         m_run[2][N];
  int         m_hold[2][N];
  bit         started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < N; c++) begin
        if (rst) begin
          m_p1[i][c] = 0; m_p2[i][c] = 0; m_lvl[i][c] = 0;
          m_prs[i][c] = 0; m_rel[i][c] = 0; m_lng[i][c] = 0;
          m_run[i][c] = 0; m_hold[i][c] = 0;
        end else begin
          bit was_high;
          was_high = m_lvl[i][c];
          m_prs[i][c] = 0;
          m_rel[i][c] = 0;
          if (m_p2[i][c] != was_high) begin
            m_run[i][c] = m_run[i][c] + 1;
            if (m_run[i][c] == DEB) begin
              m_lvl[i][c] = m_p2[i][c];
              m_run[i][c] = 0;
              m_prs[i][c] = m_p2[i][c];
              m_rel[i][c] = !m_p2[i][c];
            end
          end else begin
            m_run[i][c] = 0;
          end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
          if (was_high) begin
            m_lng[i][c] = (m_hold[i][c] == LONG - 1);
            if (m_hold[i][c] < LONG) m_hold[i][c] = m_hold[i][c] + 1;
          end else begin
            m_lng[i][c] = 0;
            m_hold[i][c] = 0;
          end
`else
          m_lng[i][c] = 0;
`endif
          m_p2[i][c] = m_p1[i][c];
          m_p1[i][c] = btn[c] ^ ((i == 1) ? INV_B[c] : 1'b0);
        end
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("model_lvl_a", lvl_a, m_lvl[0]);
      cmp("model_prs_a", prs_a, m_prs[0]);
      cmp("model_rel_a", rel_a, m_rel[0]);
      cmp("model_lng_a", lng_a, m_lng[0]);
      cmp("model_lvl_b", lvl_b, m_lvl[1]);
      cmp("model_prs_b", prs_b, m_prs[1]);
      cmp("model_rel_b", rel_b, m_rel[1]);
      cmp("model_lng_b", lng_b, m_lng[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t tbl[25];

  task automatic set_vec(input int i, input logic r, input logic [N-1:0] b,
                         input logic [N-1:0] l, input logic [N-1:0] p, input logic [N-1:0] rl);
    tbl[i].rst = r; tbl[i].btn = b; tbl[i].lvl = l; tbl[i].prs = p; tbl[i].rel = rl;
  endtask

  initial begin
    int np, k_hit, rise_c, long_c, nl, nr;
    bit lvl_seen;

    // row i: inputs driven before edge i, outputs expected right after it
    for (int i = 0; i < 2; i++)   set_vec(i, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 2; i < 7; i++)   set_vec(i, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    set_vec(7, 0, 2'b01, 2'b01, 2'b01, 2'b00);
    for (int i = 8; i < 10; i++)  set_vec(i, 0, 2'b01, 2'b01, 2'b00, 2'b00);
    for (int i = 10; i < 15; i++) set_vec(i, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    set_vec(15, 0, 2'b00, 2'b00, 2'b00, 2'b01);
    set_vec(16, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 17; i < 22; i++) set_vec(i, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    set_vec(22, 0, 2'b11, 2'b11, 2'b11, 2'b00);
    for (int i = 23; i < 25; i++) set_vec(i, 0, 2'b11, 2'b11, 2'b00, 2'b00);

    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst;
      btn = tbl[i].btn;
      step();
      cmp($sformatf("tbl%0d_lvl", i), lvl_a, tbl[i].lvl);
      cmp($sformatf("tbl%0d_prs", i), prs_a, tbl[i].prs);
      cmp($sformatf("tbl%0d_rel", i), rel_a, tbl[i].rel);
    end
    // ch1 pin held high on the active-low instance must read inactive
    cmp("inv_ch1_level", {31'd0, lvl_b[1]}, 32'd0);

    // bounce: two 3-cycle blips never reach the debounce count
    btn = 2'b00;
    for (int i = 0; i < 8; i++) step();
    np = 0; lvl_seen = 0;
    for (int i = 0; i < 14; i++) begin
      btn[0] = (i < 3) || (i >= 4 && i < 7);
      step();
      np += int'(prs_a[0]);
      lvl_seen |= lvl_a[0];
    end
    cmp("bounce_press_cnt", np, 0);
    cmp("bounce_level", {31'd0, lvl_seen}, 32'd0);

    np = 0;
    for (int i = 0; i < 10; i++) begin
      btn[0] = 1'b1;
      step();
      np += int'(prs_a[0]);
    end
    cmp("steady_press_cnt", np, 1);
    cmp("steady_level", {31'd0, lvl_a[0]}, 32'd1);

    btn[0] = 1'b0;
    k_hit = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rel_a[0] && k_hit == 0) k_hit = k;
    end
    cmp("release_edge", k_hit, 6);

    // reset while the count is one edge from completing
    btn[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      np += int'(prs_a[0]);
      cmp($sformatf("rst_zero%0d", i), {lvl_a, prs_a, rel_a, lng_a}, 32'd0);
    end
    cmp("rst_press_cnt", np, 0);
    rst = 1'b0;
    k_hit = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (prs_a[0] && k_hit == 0) k_hit = k;
    end
    cmp("rst_release_press_edge", k_hit, DEB + 2);

    // long press: hold 50 cycles, then release
    btn[0] = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rise_c = 0; long_c = 0; nl = 0;
    for (int c = 1; c <= 50; c++) begin
      btn[0] = 1'b1;
      step();
      if (lvl_a[0] && rise_c == 0) rise_c = c;
      if (lng_a[0]) begin
        nl++;
        long_c = c;
      end
    end
    cmp("long_rise_edge", rise_c, 6);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    cmp("long_pulse_cnt", nl, 1);
    cmp("long_pulse_delay", long_c - rise_c, LONG);
`else
    cmp("long_pulse_cnt", nl, 0);
`endif
    btn[0] = 1'b0;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nr += int'(rel_a[0]);
    end
    cmp("long_release_cnt", nr, 1);

    // randomized traffic; every cycle is compared by the model checker
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
